// File: rtl/cnn_window_sched.sv
// Read-port scheduler: walks 3x3 windows over a binary image and issues 9 tap reads per window.
// Optional performance counters are enabled with `define CNN_SCHED_PERF_EN.
module cnn_window_sched #(
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              core_bsy,
    output logic              ram_rd_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              pix_vld,
    output logic              pix_last,
    output logic [ADDR_W-1:0] win_col,
    output logic [ADDR_W-1:0] win_row,
    output logic              busy,
    output logic              frame_done
`ifdef CNN_SCHED_PERF_EN
    ,
    output logic [15:0]       stall_cyc,
    output logic [ADDR_W-1:0] win_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ANCHOR0  = ADDR_W'(2 * IMG_W + 2);
    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FETCH,
        ADVANCE,
        DONE
    } state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] row_reg, row_next;
    logic [ADDR_W-1:0] col_reg, col_next;
    logic [ADDR_W-1:0] anchor_reg, anchor_next;
    logic [3:0]        tap_reg, tap_next;
    logic              pix_vld_reg, pix_last_reg;
    logic              go;

    // Distance from the bottom-right anchor back to each tap, row-major from top-left.
    logic [ADDR_W-1:0] tap_off [9];
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_off
            assign tap_off[gi] = ADDR_W'((2 - gi / 3) * IMG_W + (2 - gi % 3));
        end
    endgenerate

    assign go = (anchor_reg < wr_addr) && !core_bsy;

    always_comb begin
        state_next  = state_reg;
        row_next    = row_reg;
        col_next    = col_reg;
        anchor_next = anchor_reg;
        tap_next    = tap_reg;
        ram_rd_en   = 1'b0;
        ram_addr    = '0;
        frame_done  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (frame_start) begin
                    state_next  = ARMED;
                    row_next    = TWO;
                    col_next    = TWO;
                    anchor_next = ANCHOR0;
                    tap_next    = 4'd0;
                end
            end
            ARMED: begin
                if (go) begin
                    state_next = FETCH;
                    tap_next   = 4'd0;
                end
            end
            FETCH: begin
                ram_rd_en = 1'b1;
                ram_addr  = anchor_reg - tap_off[tap_reg];
                if (tap_reg == 4'd8) begin
                    state_next = ADVANCE;
                    tap_next   = 4'd0;
                end else begin
                    tap_next = tap_reg + 4'd1;
                end
            end
            ADVANCE: begin
                if ((row_reg == ROW_LAST) && (col_reg == COL_LAST)) begin
                    state_next = DONE;
                end else begin
                    state_next = ARMED;
                    if (col_reg == COL_LAST) begin
                        // Wrap skips the two left-border pixels of the next row.
                        col_next    = TWO;
                        row_next    = row_reg + 1'b1;
                        anchor_next = anchor_reg + ADDR_W'(3);
                    end else begin
                        col_next    = col_reg + 1'b1;
                        anchor_next = anchor_reg + 1'b1;
                    end
                end
            end
            DONE: begin
                frame_done = !abort;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort) begin
            state_next  = IDLE;
            row_next    = TWO;
            col_next    = TWO;
            anchor_next = ANCHOR0;
            tap_next    = 4'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            row_reg      <= TWO;
            col_reg      <= TWO;
            anchor_reg   <= ANCHOR0;
            tap_reg      <= 4'd0;
            pix_vld_reg  <= 1'b0;
            pix_last_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            anchor_reg   <= anchor_next;
            tap_reg      <= tap_next;
            // RAM has one cycle of read latency; abort squashes the in-flight tap.
            pix_vld_reg  <= ram_rd_en && !abort;
            pix_last_reg <= ram_rd_en && (tap_reg == 4'd8) && !abort;
        end
    end

    assign busy     = (state_reg != IDLE);
    assign pix_vld  = pix_vld_reg;
    assign pix_last = pix_last_reg;
    assign win_col  = busy ? col_reg : '0;
    assign win_row  = busy ? row_reg : '0;

`ifdef CNN_SCHED_PERF_EN
    logic [15:0]       stall_cyc_reg;
    logic [ADDR_W-1:0] win_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cyc_reg <= '0;
            win_cnt_reg   <= '0;
        end else if ((state_reg == IDLE) && frame_start && !abort) begin
            stall_cyc_reg <= '0;
            win_cnt_reg   <= '0;
        end else begin
            if ((state_reg == ARMED) && !go && (stall_cyc_reg != 16'hFFFF)) begin
                stall_cyc_reg <= stall_cyc_reg + 16'd1;
            end
            if (state_reg == ADVANCE) begin
                win_cnt_reg <= win_cnt_reg + 1'b1;
            end
        end
    end

    assign stall_cyc = stall_cyc_reg;
    assign win_cnt   = win_cnt_reg;
`endif

endmodule

// File: tb/tb_cnn_window_sched.sv
// Self-checking bench for cnn_window_sched: coordinate-based read model, randomized fill/busy.
module tb_cnn_window_sched;

    localparam int W  = 28;
    localparam int H  = 28;
    localparam int AW = 10;
    localparam int NWIN = (W - 2) * (H - 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          frame_start;
    logic          abort;
    logic [AW-1:0] wr_addr;
    logic          core_bsy;
    logic          ram_rd_en;
    logic [AW-1:0] ram_addr;
    logic          pix_vld;
    logic          pix_last;
    logic [AW-1:0] win_col;
    logic [AW-1:0] win_row;
    logic          busy;
    logic          frame_done;
`ifdef CNN_SCHED_PERF_EN
    logic [15:0]   stall_cyc;
    logic [AW-1:0] win_cnt;
`endif

    cnn_window_sched #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .abort(abort),
        .wr_addr(wr_addr), .core_bsy(core_bsy), .ram_rd_en(ram_rd_en), .ram_addr(ram_addr),
        .pix_vld(pix_vld), .pix_last(pix_last), .win_col(win_col), .win_row(win_row),
        .busy(busy), .frame_done(frame_done)
`ifdef CNN_SCHED_PERF_EN
        , .stall_cyc(stall_cyc), .win_cnt(win_cnt)
`endif
    );

    always #5 clk = ~clk;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;
    int rd_idx, vld_idx, fd_cnt, fd_cyc, t0, last_start, ticks;
    bit period_chk;
    bit prev_rd;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expected tap addresses of a whole frame, from window/pixel coordinates.
    task automatic build_frame();
        exp_q.delete();
        for (int r = 2; r < H; r++)
            for (int c = 2; c < W; c++)
                for (int i = 0; i < 3; i++)
                    for (int j = 0; j < 3; j++)
                        exp_q.push_back((r - 2 + i) * W + (c - 2 + j));
        rd_idx = 0; vld_idx = 0; fd_cnt = 0; fd_cyc = -1; t0 = -1; last_start = -1;
    endtask

    task automatic tick();
        logic          s_bsy;
        logic [AW-1:0] s_wr;
        int w, er, ec, e;
        s_bsy = core_bsy;
        s_wr  = wr_addr;
        @(posedge clk);
        #1;
        cyc++;
        if (ram_rd_en) begin
            w  = rd_idx / 9;
            er = 2 + w / (W - 2);
            ec = 2 + w % (W - 2);
            if (exp_q.size() == 0) begin
                chk("extra_read", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("rd_addr", ram_addr, e);
            end
            chk("win_row", win_row, er);
            chk("win_col", win_col, ec);
            chk("rd_below_fill", (ram_addr < s_wr), 1);
            if (rd_idx % 9 == 0) begin
                chk("start_core_idle", s_bsy, 0);
                chk("start_fill", ((er * W + ec) < s_wr), 1);
                if (t0 < 0) t0 = cyc;
                if (period_chk && last_start >= 0) chk("win_period", cyc - last_start, 11);
                last_start = cyc;
            end else begin
                chk("taps_contiguous", prev_rd, 1);
            end
            rd_idx++;
        end
        if (pix_vld) begin
            chk("pix_last", pix_last, (vld_idx % 9 == 8));
            vld_idx++;
        end
        if (frame_done) begin
            fd_cnt++;
            fd_cyc = cyc;
            chk("vld_retired", vld_idx, NWIN * 9);
        end
        prev_rd = ram_rd_en;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; abort = 1'b0; wr_addr = '0; core_bsy = 1'b0;
        period_chk = 1'b0; prev_rd = 1'b0;
        build_frame();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_rd_en", ram_rd_en, 0);
        chk("rst_addr", ram_addr, 0);
        chk("rst_pix_vld", pix_vld, 0);
        chk("rst_pix_last", pix_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_win_row", win_row, 0);

        // Full frame, image already written, core idle: fixed 11-cycle cadence.
        wr_addr = AW'(W * H); core_bsy = 1'b0; period_chk = 1'b1;
        build_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("f1_busy", busy, 1);
        ticks = 0;
        while (fd_cnt == 0 && ticks < 9000) begin
            frame_start = (ticks == 3000);
            tick();
            ticks++;
        end
        frame_start = 1'b0;
        chk("f1_frame_done", fd_cnt, 1);
        chk("f1_timing", fd_cyc - t0, NWIN * 11 - 1);
        repeat (5) tick();
        chk("f1_done_once", fd_cnt, 1);
        chk("f1_reads", rd_idx, NWIN * 9);
        chk("f1_queue_empty", exp_q.size(), 0);
        chk("f1_idle", busy, 0);
`ifdef CNN_SCHED_PERF_EN
        chk("f1_win_cnt", win_cnt, NWIN);
        chk("f1_stall_cyc", stall_cyc, 0);
`endif

        // Frame with ramping fill level and random core busy.
        period_chk = 1'b0; wr_addr = '0;
        build_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks = 0;
        while (fd_cnt == 0 && ticks < 40000) begin
            if (ticks % 10 == 9 && int'(wr_addr) < W * H) wr_addr = wr_addr + AW'(8);
            if (int'(wr_addr) > W * H) wr_addr = AW'(W * H);
            core_bsy = ($urandom_range(0, 9) < 4);
            tick();
            ticks++;
        end
        core_bsy = 1'b0;
        chk("f2_frame_done", fd_cnt, 1);
        chk("f2_reads", rd_idx, NWIN * 9);
        tick();

        // Abort during tap 4 of the first window.
        wr_addr = AW'(W * H);
        build_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks = 0;
        while (rd_idx < 5 && ticks < 50) begin
            tick();
            ticks++;
        end
        chk("ab_reached_tap4", rd_idx, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_idle", busy, 0);
        chk("ab_vld_squashed", pix_vld, 0);
        begin
            int n_rd, n_vld;
            n_rd = 0; n_vld = 0;
            for (int k = 0; k < 15; k++) begin
                tick();
                n_rd += ram_rd_en;
                n_vld += pix_vld;
            end
            chk("ab_no_reads", n_rd, 0);
            chk("ab_no_vld", n_vld, 0);
            chk("ab_no_done", fd_cnt, 0);
        end
        frame_start = 1'b1; abort = 1'b1;
        tick();
        frame_start = 1'b0; abort = 1'b0;
        chk("ab_beats_start", busy, 0);

        // Restart after abort begins at address 0 again.
        build_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        ticks = 0;
        while (rd_idx < 9 && ticks < 50) begin
            tick();
            ticks++;
        end
        chk("restart_window", rd_idx, 9);

        // Reset mid-frame.
        rst_n = 1'b0;
        tick();
        chk("mrst_busy", busy, 0);
        chk("mrst_rd_en", ram_rd_en, 0);
        chk("mrst_pix_vld", pix_vld, 0);
        rst_n = 1'b1;
        repeat (10) tick();
        chk("mrst_no_done", fd_cnt, 0);
        chk("mrst_idle", busy, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
